gpio_bank: RTL and testbench

Parametrised memory-mapped GPIO bank for the CPU's load/store path; successor to the single-register output latch. Provides per-pin direction, atomic set/clear/toggle, synchronised input sampling, and edge-triggered interrupts with write-1-to-clear pending bits. Sits beside the D-Cache on the execute/memory stage. It decodes the same `uop`/`addr` pair and updates on the falling edge of `clk`.

---
 rtl/gpio_bank.sv | 133 +++++++++++++
 tb/tb_gpio_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction, atomic set/clear/toggle, synchronised inputs
// and edge interrupts with write-1-to-clear pending bits. All state moves on the falling edge.
module gpio_bank #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'd32,
    parameter logic [4:0]  STR_UOP   = 5'd9,
    parameter logic [4:0]  LDR_UOP   = 5'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       uop,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [3:0] R_OUT  = 4'd0;
    localparam logic [3:0] R_SET  = 4'd1;
    localparam logic [3:0] R_CLR  = 4'd2;
    localparam logic [3:0] R_TGL  = 4'd3;
    localparam logic [3:0] R_DIR  = 4'd4;
    localparam logic [3:0] R_IN   = 4'd5;
    localparam logic [3:0] R_RISE = 4'd6;
    localparam logic [3:0] R_FALL = 4'd7;
    localparam logic [3:0] R_PEND = 4'd8;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [1:0]       arm_cnt_q, arm_cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;

    logic [31:0]      off;
    logic [3:0]       idx;
    logic             hit, st, ld, armed;
    logic [WIDTH-1:0] wd, clr_mask, rise_ev, fall_ev;
    logic [31:0]      rd_sel;
    logic             unused_wdata;

    // Address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
    assign off          = addr - BASE_ADDR;
    assign hit          = (off <= 32'h20) && (off[1:0] == 2'b00);
    assign idx          = off[5:2];
    assign st           = hit && (uop == STR_UOP);
    assign ld           = hit && (uop == LDR_UOP);
    assign wd           = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_mask  = '0;
        if (st) begin
            case (idx)
                R_OUT:   out_d     = wd;
                R_SET:   out_d     = out_q | wd;
                R_CLR:   out_d     = out_q & ~wd;
                R_TGL:   out_d     = out_q ^ wd;
                R_DIR:   dir_d     = wd;
                R_RISE:  rise_en_d = wd;
                R_FALL:  fall_en_d = wd;
                R_PEND:  clr_mask  = wd;
                default: ;
            endcase
        end

        // Edges stay masked until the synchroniser and history flop hold real pin levels.
        armed     = (arm_cnt_q == 2'd3);
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        rise_ev   = s2_q & ~prev_q & rise_en_q & {WIDTH{armed}};
        fall_ev   = ~s2_q & prev_q & fall_en_q & {WIDTH{armed}};
        pend_d    = (pend_q & ~clr_mask) | rise_ev | fall_ev;

        rd_sel = '0;
        case (idx)
            R_OUT:   rd_sel[WIDTH-1:0] = out_q;
            R_DIR:   rd_sel[WIDTH-1:0] = dir_q;
            R_IN:    rd_sel[WIDTH-1:0] = s2_q;
            R_RISE:  rd_sel[WIDTH-1:0] = rise_en_q;
            R_FALL:  rd_sel[WIDTH-1:0] = fall_en_q;
            R_PEND:  rd_sel[WIDTH-1:0] = pend_q;
            default: rd_sel = '0;
        endcase
        rdata_d       = ld ? rd_sel : rdata_q;
        rdata_valid_d = ld;
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            out_q         <= '0;
            dir_q         <= '0;
            rise_en_q     <= '0;
            fall_en_q     <= '0;
            pend_q        <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            prev_q        <= '0;
            arm_cnt_q     <= 2'd0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            dir_q         <= dir_d;
            rise_en_q     <= rise_en_d;
            fall_en_q     <= fall_en_d;
            pend_q        <= pend_d;
            s1_q          <= gpio_in;
            s2_q          <= s1_q;
            prev_q        <= s2_q;
            arm_cnt_q     <= arm_cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign gpio_out    = out_q;
    assign gpio_oe     = dir_q;
    assign irq         = |pend_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: a 32-pin and an 8-pin instance share one bus; load results
// are checked by a scoreboard monitor, everything else inline per scenario.
module tb_gpio_bank;

    localparam logic [31:0] BASE = 32'd32;
    localparam logic [4:0]  STR  = 5'd9;
    localparam logic [4:0]  LDR  = 5'd8;
    localparam logic [4:0]  NOP  = 5'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  uop;
    logic [31:0] addr, wdata;
    logic [31:0] gpio_in;
    logic [31:0] rdata, rdata8;
    logic        rdata_valid, rdata_valid8;
    logic [31:0] gpio_out, gpio_oe;
    logic [7:0]  gpio_out8, gpio_oe8;
    logic        irq, irq8;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb32[$];
    logic [31:0] sb8[$];

    gpio_bank #(.WIDTH(32), .BASE_ADDR(BASE), .STR_UOP(STR), .LDR_UOP(LDR)) dut (
        .clk(clk), .rst_n(rst_n), .uop(uop), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_bank #(.WIDTH(8), .BASE_ADDR(BASE), .STR_UOP(STR), .LDR_UOP(LDR)) dut8 (
        .clk(clk), .rst_n(rst_n), .uop(uop), .addr(addr), .wdata(wdata),
        .rdata(rdata8), .rdata_valid(rdata_valid8), .gpio_in(gpio_in[7:0]),
        .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    // Scoreboard: each valid load output pops the expectation pushed when it was issued.
    always @(negedge clk) begin
        #1;
        if (rdata_valid) begin
            n_checks++;
            if (sb32.size() == 0) $display("FAIL load32 unexpected rdata_valid rdata=%h", rdata);
            else begin
                logic [31:0] e;
                e = sb32.pop_front();
                if (rdata !== e) $display("FAIL load32 rdata=%h expected=%h", rdata, e);
                else n_pass++;
            end
        end
        if (rdata_valid8) begin
            n_checks++;
            if (sb8.size() == 0) $display("FAIL load8 unexpected rdata_valid rdata=%h", rdata8);
            else begin
                logic [31:0] e;
                e = sb8.pop_front();
                if (rdata8 !== e) $display("FAIL load8 rdata=%h expected=%h", rdata8, e);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        uop = STR; addr = a; wdata = d;
        @(negedge clk);
        #1;
        uop = NOP;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] e32, input logic [31:0] e8);
        sb32.push_back(e32);
        sb8.push_back(e8);
        uop = LDR; addr = a;
        @(negedge clk);
        #1;
        uop = NOP;
    endtask

    task automatic load_miss(input logic [31:0] a);
        uop = LDR; addr = a;
        @(negedge clk);
        #1;
        uop = NOP;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gpio_in = 32'hFFFF_FFFF;
        idle(2);
        n_checks++;
        if ({gpio_out, gpio_oe, rdata, rdata_valid, irq} !== '0)
            $display("FAIL reset_outputs out=%h oe=%h rdata=%h vld=%b irq=%b required all 0",
                     gpio_out, gpio_oe, rdata, rdata_valid, irq);
        else n_pass++;
        n_checks++;
        if ({gpio_out8, gpio_oe8, rdata8, rdata_valid8, irq8} !== '0)
            $display("FAIL reset_outputs8 out=%h oe=%h irq=%b required all 0", gpio_out8, gpio_oe8, irq8);
        else n_pass++;
        rst_n = 1'b1;
        store(BASE + 32'h18, 32'hFFFF_FFFF);
        idle(5);
        n_checks++;
        if (irq !== 1'b0 || irq8 !== 1'b0) $display("FAIL arming_irq irq=%b irq8=%b required 0", irq, irq8);
        else n_pass++;
        load(BASE + 32'h20, 32'h0, 32'h0);
        store(BASE + 32'h18, 32'h0);
        gpio_in = 32'h0;
        idle(4);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL no_enable_irq irq=%b required 0", irq);
        else n_pass++;
    endtask

    task automatic test_atomic();
        logic [31:0] exp_out[4];
        exp_out = '{32'hF0, 32'hFF, 32'hCF, 32'h1CE};
        store(BASE + 32'h00, 32'h0000_00F0);
        n_checks++;
        if (gpio_out !== exp_out[0]) $display("FAIL atomic_str gpio_out=%h required %h", gpio_out, exp_out[0]);
        else n_pass++;
        store(BASE + 32'h04, 32'h0F);
        n_checks++;
        if (gpio_out !== exp_out[1]) $display("FAIL atomic_set gpio_out=%h required %h", gpio_out, exp_out[1]);
        else n_pass++;
        store(BASE + 32'h08, 32'h30);
        n_checks++;
        if (gpio_out !== exp_out[2]) $display("FAIL atomic_clr gpio_out=%h required %h", gpio_out, exp_out[2]);
        else n_pass++;
        store(BASE + 32'h0C, 32'h101);
        n_checks++;
        if (gpio_out !== exp_out[3]) $display("FAIL atomic_tgl gpio_out=%h required %h", gpio_out, exp_out[3]);
        else n_pass++;
        n_checks++;
        if (gpio_out8 !== 8'hCE) $display("FAIL atomic_w8 gpio_out8=%h required ce", gpio_out8);
        else n_pass++;
        load(BASE + 32'h00, 32'h1CE, 32'hCE);
        n_checks++;
        if (rdata_valid !== 1'b1) $display("FAIL ldr_valid rdata_valid=%b required 1", rdata_valid);
        else n_pass++;
        idle(1);
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h1CE)
            $display("FAIL ldr_hold rdata_valid=%b rdata=%h required 0/000001ce", rdata_valid, rdata);
        else n_pass++;
    endtask

    task automatic test_rise();
        logic [2:0] exp_irq;
        exp_irq = 3'b100;
        store(BASE + 32'h18, 32'h1);
        gpio_in = 32'h1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_checks++;
            if (irq !== exp_irq[i]) $display("FAIL rise_latency edge=%0d irq=%b required %b", i + 1, irq, exp_irq[i]);
            else n_pass++;
        end
        load(BASE + 32'h20, 32'h1, 32'h1);
        store(BASE + 32'h20, 32'h1);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL w1c_clear irq=%b required 0", irq);
        else n_pass++;
        load(BASE + 32'h14, 32'h1, 32'h1);
    endtask

    task automatic test_set_wins();
        store(BASE + 32'h1C, 32'h4);
        gpio_in = 32'h5;
        idle(3);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL pin2_rise_ignored irq=%b required 0", irq);
        else n_pass++;
        gpio_in = 32'h1;
        idle(2);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL fall_early irq=%b required 0", irq);
        else n_pass++;
        store(BASE + 32'h20, 32'h4);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL set_wins irq=%b required 1", irq);
        else n_pass++;
        load(BASE + 32'h20, 32'h4, 32'h4);
        store(BASE + 32'h20, 32'h4);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL set_wins_clear irq=%b required 0", irq);
        else n_pass++;
    endtask

    task automatic test_decode();
        store(BASE + 32'h24, 32'hFFFF_FFFF);
        store(BASE + 32'h02, 32'h0);
        store(BASE - 32'h4, 32'h0);
        n_checks++;
        if (gpio_out !== 32'h1CE || gpio_out8 !== 8'hCE || gpio_oe !== 32'h0 || gpio_oe8 !== 8'h0)
            $display("FAIL decode_miss out=%h out8=%h oe=%h oe8=%h required 000001ce/ce/0/0",
                     gpio_out, gpio_out8, gpio_oe, gpio_oe8);
        else n_pass++;
        load_miss(BASE + 32'h24);
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata_valid8 !== 1'b0)
            $display("FAIL ldr_miss_valid vld=%b vld8=%b required 0", rdata_valid, rdata_valid8);
        else n_pass++;
        load_miss(BASE + 32'h11);
        n_checks++;
        if (rdata_valid !== 1'b0) $display("FAIL ldr_unaligned_valid vld=%b required 0", rdata_valid);
        else n_pass++;
        store(BASE + 32'h10, 32'hFFFF_FFFF);
        n_checks++;
        if (gpio_oe8 !== 8'hFF || gpio_oe !== 32'hFFFF_FFFF)
            $display("FAIL dir_write oe8=%h oe=%h required ff/ffffffff", gpio_oe8, gpio_oe);
        else n_pass++;
        load(BASE + 32'h10, 32'hFFFF_FFFF, 32'h0000_00FF);
        load(BASE + 32'h04, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        store(BASE + 32'h18, 32'h3);
        gpio_in = 32'h0;
        idle(3);
        gpio_in = 32'h3;
        idle(3);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL mid_pend_irq irq=%b required 1", irq);
        else n_pass++;
        load(BASE + 32'h20, 32'h3, 32'h3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        n_checks++;
        if (irq !== 1'b0 || gpio_out !== 32'h0 || gpio_oe !== 32'h0 || rdata !== 32'h0)
            $display("FAIL mid_reset irq=%b out=%h oe=%h rdata=%h required 0", irq, gpio_out, gpio_oe, rdata);
        else n_pass++;
        store(BASE + 32'h18, 32'h3);
        idle(5);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL rearm_mask irq=%b required 0", irq);
        else n_pass++;
        load(BASE + 32'h20, 32'h0, 32'h0);
        load(BASE + 32'h00, 32'h0, 32'h0);
        gpio_in = 32'h0;
        idle(3);
        gpio_in = 32'h1;
        idle(3);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL rearmed_detect irq=%b required 1", irq);
        else n_pass++;
    endtask

    initial begin
        uop = NOP; addr = 32'h0; wdata = 32'h0; rst_n = 1'b0; gpio_in = 32'h0;
        test_reset();
        test_atomic();
        test_rise();
        test_set_wins();
        test_decode();
        test_reset_mid();
        idle(2);
        n_checks++;
        if (sb32.size() != 0 || sb8.size() != 0)
            $display("FAIL scoreboard_drain left32=%0d left8=%0d required 0", sb32.size(), sb8.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
